// File: rtl/result_select_stage.sv
// Result classifier with rounding-mode-aware overflow handling, feeding a
// 2-entry valid/ready skid buffer and sticky exception flags.
package sign;
    typedef enum logic [1:0] {ZERO = 2'd0, ONE = 2'd1, RESULT = 2'd2} select_t;
endpackage

package exponent;
    typedef enum logic [1:0] {ZEROS = 2'd0, ONES = 2'd1, RESULT = 2'd2, MAX_NORMAL = 2'd3} select_t;
endpackage

package fraction_msb;
    typedef enum logic [1:0] {ZERO = 2'd0, ONES = 2'd1, RESULT = 2'd2} select_t;
endpackage

package fraction_lsbs;
    typedef enum logic [1:0] {ZEROS = 2'd0, ONES = 2'd1, RESULT = 2'd2} select_t;
endpackage

module result_select_stage #(
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned FRAC_WIDTH = 23
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  sign::select_t              sign_select_in,
    input  exponent::select_t          exponent_select_in,
    input  fraction_msb::select_t      fraction_msb_select_in,
    input  fraction_lsbs::select_t     fraction_lsbs_select_in,
    input  logic [1:0]                 round_mode,
    input  logic                       result_sign,
    input  logic [EXP_WIDTH+1:0]       result_exponent,
    input  logic [FRAC_WIDTH+1:0]      result_fraction,
    output logic                       out_valid,
    input  logic                       out_ready,
    output sign::select_t              sign_select_out,
    output exponent::select_t          exponent_select_out,
    output fraction_msb::select_t      fraction_msb_select_out,
    output fraction_lsbs::select_t     fraction_lsbs_select_out,
    output logic                       result_sign_out,
    output logic [EXP_WIDTH-1:0]       result_exponent_out,
    output logic [FRAC_WIDTH-1:0]      result_fraction_out,
    output logic                       flag_overflow,
    output logic                       flag_underflow,
    output logic                       flag_zero,
    input  logic                       flag_clear
);

    typedef struct packed {
        sign::select_t          sgn_sel;
        exponent::select_t      exp_sel;
        fraction_msb::select_t  msb_sel;
        fraction_lsbs::select_t lsb_sel;
        logic                   sgn;
        logic [EXP_WIDTH-1:0]   exp;
        logic [FRAC_WIDTH-1:0]  frac;
    } entry_t;

    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_FULL = 2'd2} state_t;

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q, in_ready_d;
    logic   out_valid_q, out_valid_d;
    logic   flag_overflow_q, flag_overflow_d;
    logic   flag_underflow_q, flag_underflow_d;
    logic   flag_zero_q, flag_zero_d;

    entry_t entry_in;
    logic   all_result, is_zero, is_ovf, is_unf, use_max_finite;
    logic   set_zero, set_ovf, set_unf;
    logic   push, pop;

    // Exponent is two's complement: overflow needs a non-negative value whose
    // low EXP_WIDTH+1 bits reach the all-ones packed exponent.
    always_comb begin
        all_result = (sign_select_in == sign::RESULT)
                   && (exponent_select_in == exponent::RESULT)
                   && (fraction_msb_select_in == fraction_msb::RESULT)
                   && (fraction_lsbs_select_in == fraction_lsbs::RESULT);
        is_zero = ~|result_fraction;
        is_ovf  = ~result_exponent[EXP_WIDTH+1]
                  && (result_exponent[EXP_WIDTH:0] >= {1'b0, {EXP_WIDTH{1'b1}}});
        is_unf  = result_exponent[EXP_WIDTH+1] || (result_exponent == '0);
        use_max_finite = (round_mode == 2'd1)
                       || ((round_mode == 2'd2) && !result_sign)
                       || ((round_mode == 2'd3) && result_sign);

        entry_in.sgn_sel = sign_select_in;
        entry_in.exp_sel = exponent_select_in;
        entry_in.msb_sel = fraction_msb_select_in;
        entry_in.lsb_sel = fraction_lsbs_select_in;
        entry_in.sgn     = result_sign;
        entry_in.exp     = result_exponent[EXP_WIDTH-1:0];
        entry_in.frac    = result_fraction[FRAC_WIDTH-1:0];
        set_zero = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;

        if (all_result) begin
            if (is_zero) begin
                set_zero         = 1'b1;
                entry_in.sgn_sel = sign::ZERO;
                entry_in.exp_sel = exponent::ZEROS;
                entry_in.msb_sel = fraction_msb::ZERO;
                entry_in.lsb_sel = fraction_lsbs::ZEROS;
            end else if (is_ovf && !is_unf) begin
                set_ovf = 1'b1;
                if (use_max_finite) begin
                    entry_in.exp_sel = exponent::MAX_NORMAL;
                    entry_in.msb_sel = fraction_msb::ONES;
                    entry_in.lsb_sel = fraction_lsbs::ONES;
                end else begin
                    entry_in.exp_sel = exponent::ONES;
                    entry_in.msb_sel = fraction_msb::ZERO;
                    entry_in.lsb_sel = fraction_lsbs::ZEROS;
                end
            end else if (is_unf && !is_ovf) begin
                set_unf          = 1'b1;
                entry_in.exp_sel = exponent::ZEROS;
                entry_in.msb_sel = fraction_msb::ZERO;
                entry_in.lsb_sel = fraction_lsbs::ZEROS;
            end
        end
    end

    always_comb begin
        push    = in_valid && in_ready_q;
        pop     = out_valid_q && out_ready;
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;

        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    head_d  = entry_in;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_d = entry_in;
                end else if (push) begin
                    skid_d  = entry_in;
                    state_d = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    head_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);

        // A set on push outranks a same-cycle clear.
        flag_overflow_d  = (push && set_ovf)  || (flag_overflow_q  && !flag_clear);
        flag_underflow_d = (push && set_unf)  || (flag_underflow_q && !flag_clear);
        flag_zero_d      = (push && set_zero) || (flag_zero_q      && !flag_clear);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_EMPTY;
            head_q           <= '0;
            skid_q           <= '0;
            in_ready_q       <= 1'b1;
            out_valid_q      <= 1'b0;
            flag_overflow_q  <= 1'b0;
            flag_underflow_q <= 1'b0;
            flag_zero_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            head_q           <= head_d;
            skid_q           <= skid_d;
            in_ready_q       <= in_ready_d;
            out_valid_q      <= out_valid_d;
            flag_overflow_q  <= flag_overflow_d;
            flag_underflow_q <= flag_underflow_d;
            flag_zero_q      <= flag_zero_d;
        end
    end

    assign in_ready                 = in_ready_q;
    assign out_valid                = out_valid_q;
    assign sign_select_out          = head_q.sgn_sel;
    assign exponent_select_out      = head_q.exp_sel;
    assign fraction_msb_select_out  = head_q.msb_sel;
    assign fraction_lsbs_select_out = head_q.lsb_sel;
    assign result_sign_out          = head_q.sgn;
    assign result_exponent_out      = head_q.exp;
    assign result_fraction_out      = head_q.frac;
    assign flag_overflow            = flag_overflow_q;
    assign flag_underflow           = flag_underflow_q;
    assign flag_zero                = flag_zero_q;

endmodule

// File: tb/tb_result_select_stage.sv
// Bench for result_select_stage: directed scenarios plus a randomized run
// against a queue-based reference model of the classifier and buffer.
module tb_result_select_stage;

    localparam int unsigned EW = 8;
    localparam int unsigned FW = 23;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   in_valid;
    logic                   in_ready;
    sign::select_t          sign_select_in;
    exponent::select_t      exponent_select_in;
    fraction_msb::select_t  fraction_msb_select_in;
    fraction_lsbs::select_t fraction_lsbs_select_in;
    logic [1:0]             round_mode;
    logic                   result_sign;
    logic [EW+1:0]          result_exponent;
    logic [FW+1:0]          result_fraction;
    logic                   out_valid;
    logic                   out_ready;
    sign::select_t          sign_select_out;
    exponent::select_t      exponent_select_out;
    fraction_msb::select_t  fraction_msb_select_out;
    fraction_lsbs::select_t fraction_lsbs_select_out;
    logic                   result_sign_out;
    logic [EW-1:0]          result_exponent_out;
    logic [FW-1:0]          result_fraction_out;
    logic                   flag_overflow;
    logic                   flag_underflow;
    logic                   flag_zero;
    logic                   flag_clear;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        sign::select_t          s;
        exponent::select_t      e;
        fraction_msb::select_t  m;
        fraction_lsbs::select_t l;
        logic                   sg;
        logic [EW-1:0]          ex;
        logic [FW-1:0]          fr;
    } out_t;

    typedef struct packed {
        sign::select_t          s;
        exponent::select_t      e;
        fraction_msb::select_t  m;
        fraction_lsbs::select_t l;
        logic [1:0]             rm;
        logic                   sg;
        logic [EW+1:0]          ex;
        logic [FW+1:0]          fr;
    } in_t;

    result_select_stage #(.EXP_WIDTH(EW), .FRAC_WIDTH(FW)) dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .in_valid                 (in_valid),
        .in_ready                 (in_ready),
        .sign_select_in           (sign_select_in),
        .exponent_select_in       (exponent_select_in),
        .fraction_msb_select_in   (fraction_msb_select_in),
        .fraction_lsbs_select_in  (fraction_lsbs_select_in),
        .round_mode               (round_mode),
        .result_sign              (result_sign),
        .result_exponent          (result_exponent),
        .result_fraction          (result_fraction),
        .out_valid                (out_valid),
        .out_ready                (out_ready),
        .sign_select_out          (sign_select_out),
        .exponent_select_out      (exponent_select_out),
        .fraction_msb_select_out  (fraction_msb_select_out),
        .fraction_lsbs_select_out (fraction_lsbs_select_out),
        .result_sign_out          (result_sign_out),
        .result_exponent_out      (result_exponent_out),
        .result_fraction_out      (result_fraction_out),
        .flag_overflow            (flag_overflow),
        .flag_underflow           (flag_underflow),
        .flag_zero                (flag_zero),
        .flag_clear               (flag_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    function automatic out_t obs();
        out_t o;
        o.s  = sign_select_out;
        o.e  = exponent_select_out;
        o.m  = fraction_msb_select_out;
        o.l  = fraction_lsbs_select_out;
        o.sg = result_sign_out;
        o.ex = result_exponent_out;
        o.fr = result_fraction_out;
        return o;
    endfunction

    function automatic in_t mk(input int e, input logic [FW+1:0] f, input logic [1:0] rm, input logic sg);
        in_t i;
        i.s  = sign::RESULT;
        i.e  = exponent::RESULT;
        i.m  = fraction_msb::RESULT;
        i.l  = fraction_lsbs::RESULT;
        i.rm = rm;
        i.sg = sg;
        i.ex = (EW+2)'(e);
        i.fr = f;
        return i;
    endfunction

    function automatic out_t exp_out(input in_t i, input sign::select_t s, input exponent::select_t e,
                                     input fraction_msb::select_t m, input fraction_lsbs::select_t l);
        out_t o;
        o.s  = s;
        o.e  = e;
        o.m  = m;
        o.l  = l;
        o.sg = i.sg;
        o.ex = i.ex[EW-1:0];
        o.fr = i.fr[FW-1:0];
        return o;
    endfunction

    // Reference classifier from the rules; f = {overflow, underflow, zero}.
    function automatic void ref_model(input in_t i, output out_t o, output logic [2:0] f);
        int  e;
        bit  maxf;
        e = int'($signed(i.ex));
        o = exp_out(i, i.s, i.e, i.m, i.l);
        f = 3'b000;
        if (i.s == sign::RESULT && i.e == exponent::RESULT &&
            i.m == fraction_msb::RESULT && i.l == fraction_lsbs::RESULT) begin
            if (i.fr == 0) begin
                o = exp_out(i, sign::ZERO, exponent::ZEROS, fraction_msb::ZERO, fraction_lsbs::ZEROS);
                f = 3'b001;
            end else if (e >= (1 << EW) - 1) begin
                maxf = (i.rm == 1) || (i.rm == 2 && i.sg == 0) || (i.rm == 3 && i.sg == 1);
                if (maxf)
                    o = exp_out(i, sign::RESULT, exponent::MAX_NORMAL, fraction_msb::ONES, fraction_lsbs::ONES);
                else
                    o = exp_out(i, sign::RESULT, exponent::ONES, fraction_msb::ZERO, fraction_lsbs::ZEROS);
                f = 3'b100;
            end else if (e <= 0) begin
                o = exp_out(i, sign::RESULT, exponent::ZEROS, fraction_msb::ZERO, fraction_lsbs::ZEROS);
                f = 3'b010;
            end
        end
    endfunction

    task automatic drive(input in_t i);
        sign_select_in          = i.s;
        exponent_select_in      = i.e;
        fraction_msb_select_in  = i.m;
        fraction_lsbs_select_in = i.l;
        round_mode              = i.rm;
        result_sign             = i.sg;
        result_exponent         = i.ex;
        result_fraction         = i.fr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_and_drain();
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        flag_clear = 1'b1;
        tick();
        tick();
        tick();
        flag_clear = 1'b0;
    endtask

    task automatic test_reset();
        out_t z;
        z = '0;
        z.s = sign::ZERO;
        z.e = exponent::ZEROS;
        z.m = fraction_msb::ZERO;
        z.l = fraction_lsbs::ZEROS;
        reset_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        flag_clear = 1'b0;
        drive(mk(0, '0, 2'd0, 1'b0));
        #23;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: got valid=%b ready=%b, want valid=0 ready=1", out_valid, in_ready);
        end
        checks++;
        if (obs() !== z || {flag_overflow, flag_underflow, flag_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: got %h flags=%b, want %h flags=000", obs(), {flag_overflow, flag_underflow, flag_zero}, z);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_overflow_modes();
        // {round_mode, sign, expect max-finite}
        logic [3:0] cases [6] = '{4'b00_0_0, 4'b01_0_1, 4'b11_1_1, 4'b11_0_0, 4'b10_0_1, 4'b10_1_0};
        in_t  i;
        out_t e;
        for (int k = 0; k < 6; k++) begin
            clear_and_drain();
            i = mk(255, 25'h1234, cases[k][3:2], cases[k][1]);
            e = cases[k][0] ?
                exp_out(i, sign::RESULT, exponent::MAX_NORMAL, fraction_msb::ONES, fraction_lsbs::ONES) :
                exp_out(i, sign::RESULT, exponent::ONES, fraction_msb::ZERO, fraction_lsbs::ZEROS);
            drive(i);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || obs() !== e) begin
                errors++;
                $display("FAIL overflow_case%0d: got valid=%b %h, want valid=1 %h", k, out_valid, obs(), e);
            end
            checks++;
            if ({flag_overflow, flag_underflow, flag_zero} !== 3'b100) begin
                errors++;
                $display("FAIL overflow_flags%0d: got %b, want 100", k, {flag_overflow, flag_underflow, flag_zero});
            end
        end
    endtask

    task automatic test_underflow_zero_passthrough();
        in_t  i;
        out_t e;
        clear_and_drain();
        i = mk(-1, 25'h1, 2'd0, 1'b0);
        e = exp_out(i, sign::RESULT, exponent::ZEROS, fraction_msb::ZERO, fraction_lsbs::ZEROS);
        drive(i);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (obs() !== e || {flag_overflow, flag_underflow, flag_zero} !== 3'b010) begin
            errors++;
            $display("FAIL underflow: got %h flags=%b, want %h flags=010", obs(), {flag_overflow, flag_underflow, flag_zero}, e);
        end

        clear_and_drain();
        i = mk(255, '0, 2'd0, 1'b1);
        e = exp_out(i, sign::ZERO, exponent::ZEROS, fraction_msb::ZERO, fraction_lsbs::ZEROS);
        drive(i);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (obs() !== e || {flag_overflow, flag_underflow, flag_zero} !== 3'b001) begin
            errors++;
            $display("FAIL zero_case: got %h flags=%b, want %h flags=001", obs(), {flag_overflow, flag_underflow, flag_zero}, e);
        end

        clear_and_drain();
        i = mk(255, 25'h55, 2'd0, 1'b0);
        i.s = sign::ONE;
        i.l = fraction_lsbs::ONES;
        e = exp_out(i, sign::ONE, exponent::RESULT, fraction_msb::RESULT, fraction_lsbs::ONES);
        drive(i);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (obs() !== e || {flag_overflow, flag_underflow, flag_zero} !== 3'b000) begin
            errors++;
            $display("FAIL passthrough: got %h flags=%b, want %h flags=000", obs(), {flag_overflow, flag_underflow, flag_zero}, e);
        end
    endtask

    task automatic test_back_to_back();
        in_t  a, b, c;
        out_t ea, eb, ec;
        clear_and_drain();
        a = mk(100, 25'h11, 2'd0, 1'b0);
        b = mk(101, 25'h22, 2'd1, 1'b1);
        c = mk(102, 25'h33, 2'd2, 1'b0);
        ea = exp_out(a, sign::RESULT, exponent::RESULT, fraction_msb::RESULT, fraction_lsbs::RESULT);
        eb = exp_out(b, sign::RESULT, exponent::RESULT, fraction_msb::RESULT, fraction_lsbs::RESULT);
        ec = exp_out(c, sign::RESULT, exponent::RESULT, fraction_msb::RESULT, fraction_lsbs::RESULT);
        out_ready = 1'b0;
        drive(a);
        in_valid = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || obs() !== ea) begin
            errors++;
            $display("FAIL b2b_first: got ready=%b valid=%b %h, want ready=1 valid=1 %h", in_ready, out_valid, obs(), ea);
        end
        drive(b);
        tick();
        checks++;
        if (in_ready !== 1'b0 || obs() !== ea) begin
            errors++;
            $display("FAIL b2b_full: got ready=%b %h, want ready=0 %h", in_ready, obs(), ea);
        end
        drive(c);
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs() !== ea) begin
            errors++;
            $display("FAIL b2b_stall: got ready=%b valid=%b %h, want ready=0 valid=1 %h", in_ready, out_valid, obs(), ea);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || obs() !== eb) begin
            errors++;
            $display("FAIL b2b_second: got ready=%b valid=%b %h, want ready=1 valid=1 %h", in_ready, out_valid, obs(), eb);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || obs() !== ec) begin
            errors++;
            $display("FAIL b2b_third: got valid=%b %h, want valid=1 %h", out_valid, obs(), ec);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drain: got valid=%b ready=%b, want valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_flag_clear();
        clear_and_drain();
        drive(mk(300, 25'h7, 2'd0, 1'b0));
        in_valid = 1'b1;
        flag_clear = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (flag_overflow !== 1'b1) begin
            errors++;
            $display("FAIL clear_vs_set: got flag_overflow=%b, want 1", flag_overflow);
        end
        tick();
        flag_clear = 1'b0;
        checks++;
        if (flag_overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_alone: got flag_overflow=%b, want 0", flag_overflow);
        end
    endtask

    task automatic test_reset_full();
        in_t  i;
        out_t e;
        clear_and_drain();
        out_ready = 1'b0;
        drive(mk(255, 25'h9, 2'd0, 1'b0));
        in_valid = 1'b1;
        tick();
        drive(mk(0, 25'h9, 2'd0, 1'b0));
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || {flag_overflow, flag_underflow} !== 2'b11) begin
            errors++;
            $display("FAIL prereset_full: got ready=%b flags=%b, want ready=0 ovf/unf=11", in_ready, {flag_overflow, flag_underflow});
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {flag_overflow, flag_underflow, flag_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_full: got valid=%b ready=%b flags=%b, want 0 1 000", out_valid, in_ready, {flag_overflow, flag_underflow, flag_zero});
        end
        #2;
        reset_n = 1'b1;
        out_ready = 1'b1;
        i = mk(50, 25'h1ABCDE, 2'd3, 1'b1);
        e = exp_out(i, sign::RESULT, exponent::RESULT, fraction_msb::RESULT, fraction_lsbs::RESULT);
        drive(i);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || obs() !== e) begin
            errors++;
            $display("FAIL post_reset_push: got valid=%b ready=%b %h, want 1 1 %h", out_valid, in_ready, obs(), e);
        end
    endtask

    function automatic in_t rand_in();
        in_t i;
        i = mk(0, '0, 2'($urandom), 1'($urandom));
        if ($urandom_range(0, 3) == 0) begin
            i.s = sign::select_t'(2'($urandom_range(0, 2)));
            i.e = exponent::select_t'(2'($urandom_range(0, 3)));
            i.m = fraction_msb::select_t'(2'($urandom_range(0, 2)));
            i.l = fraction_lsbs::select_t'(2'($urandom_range(0, 2)));
        end
        case ($urandom_range(0, 2))
            0:       i.ex = (EW+2)'($urandom);
            1:       i.ex = (EW+2)'(253 + int'($urandom_range(0, 4)));
            default: i.ex = (EW+2)'(int'($urandom_range(0, 4)) - 2);
        endcase
        i.fr = ($urandom_range(0, 3) == 0) ? '0 : (FW+2)'($urandom);
        return i;
    endfunction

    task automatic test_random();
        out_t       q[$];
        out_t       o;
        logic [2:0] f;
        logic [2:0] fl;
        in_t        cur;
        bit         holding, push, pop, iv, clr;
        clear_and_drain();
        fl = 3'b000;
        holding = 1'b0;
        cur = rand_in();
        for (int n = 0; n < 400; n++) begin
            if (!holding) cur = rand_in();
            iv  = holding || ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            drive(cur);
            in_valid   = iv;
            out_ready  = ($urandom_range(0, 3) != 0);
            flag_clear = clr;
            push = iv && (q.size() < 2);
            pop  = out_ready && (q.size() > 0);
            holding = iv && !push;
            tick();
            if (pop) void'(q.pop_front());
            f = 3'b000;
            if (push) begin
                ref_model(cur, o, f);
                q.push_back(o);
            end
            fl = f | (clr ? 3'b000 : fl);
            checks++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                errors++;
                $display("FAIL rand_hs@%0d: got valid=%b ready=%b, want valid=%b ready=%b", n, out_valid, in_ready, q.size() > 0, q.size() < 2);
            end
            if (q.size() > 0) begin
                checks++;
                if (obs() !== q[0]) begin
                    errors++;
                    $display("FAIL rand_data@%0d: got %h, want %h", n, obs(), q[0]);
                end
            end
            checks++;
            if ({flag_overflow, flag_underflow, flag_zero} !== fl) begin
                errors++;
                $display("FAIL rand_flags@%0d: got %b, want %b", n, {flag_overflow, flag_underflow, flag_zero}, fl);
            end
        end
        in_valid = 1'b0;
        flag_clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_overflow_modes();
        test_underflow_zero_passthrough();
        test_back_to_back();
        test_flag_clear();
        test_reset_full();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
